// File: rtl/bpsk_demod_depacker.sv
// BPSK subcarrier demodulator: drops null bins, hard-slices each data bin's real part and
// packs the bits LSB-first into output words, with frame-alignment checking against s_tlast.
module bpsk_demod_depacker #(
  parameter int unsigned FFT_SIZE             = 1024,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned LO_FIRST             = 1,
  parameter int unsigned LO_LAST              = 400,
  parameter int unsigned HI_FIRST             = 623,
  parameter int unsigned HI_LAST              = 1022
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            reset_mod,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] wdata,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] rdata,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_tlast,
  output logic                            frame_err,
  output logic [15:0]                     frame_cnt,
  output logic [1:0]                      st
);

  localparam int unsigned W    = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned IdxW = $clog2(FFT_SIZE);
  localparam int unsigned BcW  = $clog2(W);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(FFT_SIZE - 1);
  localparam logic [IdxW-1:0] LoFirst = IdxW'(LO_FIRST);
  localparam logic [IdxW-1:0] LoLast  = IdxW'(LO_LAST);
  localparam logic [IdxW-1:0] HiFirst = IdxW'(HI_FIRST);
  localparam logic [IdxW-1:0] HiLast  = IdxW'(HI_LAST);
  localparam logic [BcW-1:0]  BcLast  = BcW'(W - 1);

  typedef enum logic [1:0] {
    StAligned = 2'd0,
    StHunt    = 2'd1
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] sc_idx_q, sc_idx_d;
  logic [BcW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [W-2:0]    shift_q, shift_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic            m_valid_q, m_valid_d;
  logic            m_tlast_q, m_tlast_d;
  logic            frame_err_q, frame_err_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic clear;
  logic is_data;
  logic data_bit;
  logic accept;
  logic emit;
  logic unused_wdata;

  assign unused_wdata = ^{wdata[C_S_AXIS_TDATA_WIDTH-1:16], wdata[14:0]};

  assign clear    = rst | reset_mod;
  assign is_data  = ((sc_idx_q >= LoFirst) && (sc_idx_q <= LoLast)) ||
                    ((sc_idx_q >= HiFirst) && (sc_idx_q <= HiLast));
  assign data_bit = ~wdata[15];

  // Only a word-completing sample can collide with a held output word.
  assign s_ready = !clear && !(m_valid_q && !m_ready && (bit_cnt_q == BcLast));
  assign accept  = s_valid && s_ready;
  assign emit    = m_valid_q && m_ready;

  always_comb begin
    state_d     = state_q;
    sc_idx_d    = sc_idx_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    m_valid_d   = m_valid_q;
    m_tlast_d   = m_tlast_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;

    if (emit) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        StAligned: begin
          if (is_data) begin
            if (bit_cnt_q == BcLast) begin
              rdata_d   = {data_bit, shift_q};
              m_valid_d = 1'b1;
              m_tlast_d = (sc_idx_q == HiLast);
              bit_cnt_d = '0;
              shift_d   = '0;
            end else begin
              shift_d[bit_cnt_q] = data_bit;
              bit_cnt_d          = bit_cnt_q + 1'b1;
            end
          end

          if (sc_idx_q == IdxLast) begin
            sc_idx_d = '0;
            if (s_tlast) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StHunt;
              bit_cnt_d   = '0;
              shift_d     = '0;
            end
          end else if (s_tlast) begin
            // Truncated frame: restart at index 0, dropping the partial word.
            frame_err_d = 1'b1;
            sc_idx_d    = '0;
            bit_cnt_d   = '0;
            shift_d     = '0;
          end else begin
            sc_idx_d = sc_idx_q + 1'b1;
          end
        end

        StHunt: begin
          if (s_tlast) begin
            state_d   = StAligned;
            sc_idx_d  = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end

        default: state_d = StAligned;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StAligned;
      sc_idx_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      m_valid_q   <= 1'b0;
      m_tlast_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sc_idx_q    <= sc_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      m_valid_q   <= m_valid_d;
      m_tlast_q   <= m_tlast_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rdata     = rdata_q;
  assign m_valid   = m_valid_q;
  assign m_tlast   = m_tlast_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
  assign st        = state_q;

endmodule

// File: doc/bpsk_demod_depacker.md
Name: bpsk_demod_depacker

Overview:
- Receive-side counterpart of the BPSK subcarrier modulator.
- Consumes AXI-Stream frames of FFT_SIZE complex samples, one per subcarrier, from the FFT output.
- Discards the null subcarriers, hard-slices the real part of each data subcarrier to one bit, and packs the bits LSB-first into C_M_AXIS_TDATA_WIDTH-bit words for the downstream AXI-Stream consumer.
- Checks frame alignment against s_tlast and resynchronises after a framing error.

Parameters:
- FFT_SIZE, 1024, samples per frame; s_tlast is expected on index FFT_SIZE-1.
- C_S_AXIS_TDATA_WIDTH, 32, sample width: {imag[31:16], real[15:0]}, two's complement.
- C_M_AXIS_TDATA_WIDTH, 32, packed output word width, W.
- LO_FIRST, 1, first data index of the lower band.
- LO_LAST, 400, last data index of the lower band.
- HI_FIRST, 623, first data index of the upper band.
- HI_LAST, 1022, last data index of the upper band.
- Legality: data count (LO_LAST-LO_FIRST+1)+(HI_LAST-HI_FIRST+1) must be a multiple of W. Defaults give 800 bits = 25 words per frame.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- reset_mod  in  1  synchronous soft clear; identical effect to rst.
- wdata  in  C_S_AXIS_TDATA_WIDTH  input sample.
- s_valid  in  1  input valid.
- s_ready  out  1  input ready.
- s_tlast  in  1  last sample of frame.
- rdata  out  C_M_AXIS_TDATA_WIDTH  packed bit word.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.
- m_tlast  out  1  last word of frame.
- frame_err  out  1  sticky framing error.
- frame_cnt  out  16  frames completed without error (wraps).
- st  out  2  debug state: 0 ALIGNED, 1 HUNT.

Behaviour:
- One clock: clk. Reset rst is synchronous and active-high. rst or reset_mod (rst has priority) clears:
  - state=ALIGNED, sc_idx=0, bit_cnt=0, shift=0
  - m_valid=0, rdata=0, m_tlast=0
  - frame_err=0, frame_cnt=0
- s_ready is 0 during rst or reset_mod.
- Accept: s_valid && s_ready. Emit: m_valid && m_ready.
- s_ready = !(m_valid && !m_ready && bit_cnt==W-1). This is a conservative stall: only a word-completing sample can be blocked.
- Data subcarrier: LO_FIRST<=sc_idx<=LO_LAST or HI_FIRST<=sc_idx<=HI_LAST. All other indices are null and are consumed without effect.
- Slicer: bit = ~wdata[15]. Real part >=0 gives 1 (0x7FFF->1, 0x0000->1); negative gives 0 (0x8001->0). Imaginary part is ignored.
- Packing: the k-th data bit of a word goes to bit k (LSB first).
  - A word-completing accept loads rdata={bit, shift[W-2:0]} and sets m_valid the next cycle (latency 1).
  - bit_cnt returns to 0.
  - m_tlast=1 iff that word completes at sc_idx==HI_LAST.
- rdata and m_tlast hold stable while m_valid && !m_ready.
- m_valid clears on emit, unless a new word loads in the same cycle; then it stays 1 with new data.
- ALIGNED, accept with s_tlast=1 at sc_idx==FFT_SIZE-1: normal frame end. sc_idx=0, frame_cnt+1 unless frame_err was set during this frame.
- ALIGNED, accept with s_tlast=1 at sc_idx<FFT_SIZE-1: early end.
  - frame_err=1.
  - Partial word discarded (bit_cnt=0, shift=0).
  - sc_idx=0; stay ALIGNED.
  - Any word already in the output register is still delivered.
  - No m_tlast is generated for the truncated frame.
- ALIGNED, accept with s_tlast=0 at sc_idx==FFT_SIZE-1: missing tlast.
  - frame_err=1; go to HUNT.
  - Partial word discarded.
- HUNT: accepts and discards all samples (s_ready=1 whenever not stalled by the output register). Accept with s_tlast=1 moves to ALIGNED with sc_idx=0, bit_cnt=0.
- frame_err clears only on rst or reset_mod.
- sc_idx increments on every accept in ALIGNED. Width is clog2(FFT_SIZE). It never exceeds FFT_SIZE-1.
- Reset mid-frame or mid-stall takes effect the same cycle: the output word is dropped and m_valid=0 next cycle.

Test Plan:
- Send one 1024-sample frame with m_ready=1: data indices carry 0x00007FFF on even data positions and 0x00008001 on odd ones, nulls carry 0xFFFF8001. Expect 25 words, each 0x55555555; m_tlast only on word 25, which appears 1 cycle after the index-1022 accept; frame_cnt=1; frame_err=0.
- Send an all-0x7FFF frame, then an all-0x8001 frame, back-to-back. Expect 25×0xFFFFFFFF then 25×0x00000000, and frame_cnt=2. Real value 0x0000 on one data index yields a 1 in the corresponding bit.
- Hold m_ready=0 through the first word completion. Expect s_ready to drop when bit_cnt==31 with m_valid=1, rdata stable, and no sample lost. Release m_ready: exactly 25 words and a correct bit pattern.
- Assert s_tlast at index 500. Expect frame_err=1, frame_cnt unchanged, and the partial word discarded. The next good frame yields 25 correct words with m_tlast, and frame_cnt increments.
- Omit s_tlast at index 1023. Expect frame_err=1 and st=1. The next 300 samples produce no output. s_tlast on the 300th returns st=0; the following good frame is decoded correctly.
- Assert reset_mod mid-frame while m_valid=1 and m_ready=0. The next cycle shows m_valid=0, frame_err=0 and frame_cnt=0, and a fresh frame decodes from index 0.
